pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
REQ-002 Parameter TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 stall  in  1  hold PC, suppress new fetch request.
REQ-007 redirect_valid  in  1  branch/jump redirect request, single-cycle pulse.
REQ-008 redirect_target  in  32  redirect destination, sampled when redirect_valid=1.
REQ-009 trap  in  1  trap request, single-cycle pulse.
REQ-010 halt  in  1  stop fetching after current fetch completes.
REQ-011 imem_ready  in  1  instruction memory completes the presented request this cycle.
REQ-012 imem_req  out  1  fetch request to instruction memory.
REQ-013 imem_addr  out  32  fetch address; always equals pc.
REQ-014 pc  out  32  current program counter, registered.
REQ-015 fetch_valid  out  1  one-cycle pulse: fetch at pc completed and is not squashed.
REQ-016 misaligned  out  1  one-cycle pulse: redirect target with [1:0]!=0 converted to trap.

Function
REQ-017 States: BOOT, FETCH, WAIT, HALT; state and pc are the only architectural registers, plus pending-redirect flag and pending-target register.
REQ-018 BOOT: imem_req=0; unconditionally -> FETCH next cycle.
REQ-019 FETCH: imem_req=!stall; if imem_req and imem_ready -> fetch complete this cycle; if imem_req and !imem_ready -> WAIT.
REQ-020 WAIT: imem_req=1, imem_addr held stable; stall ignored; on imem_ready -> fetch complete, -> FETCH (or HALT per REQ-026).
REQ-021 Fetch complete: fetch_valid=1 same cycle unless squashed; pc <= pc+4 at that edge, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 Next-PC priority per cycle: trap > redirect_valid > pending redirect > fetch-complete increment > hold.
REQ-023 trap or redirect in FETCH: pc loaded at next edge (TRAP_VECTOR or redirect_target); any fetch completing that cycle is squashed (fetch_valid=0).
REQ-024 trap or redirect in WAIT: target captured as pending; request held until imem_ready; completing fetch squashed; pc <= pending target at that edge; pending cleared. A later trap overwrites a pending redirect; a later redirect overwrites a pending redirect but not a pending trap.
REQ-025 redirect_target[1:0]!=0: treated as trap (TRAP_VECTOR), misaligned=1 in the cycle redirect_valid is sampled.
REQ-026 halt in FETCH with no fetch completing -> HALT next edge; halt in WAIT takes effect at fetch completion; halt coincident with trap or redirect: trap/redirect applied, halt still taken.
REQ-027 HALT: imem_req=0, pc held; redirect_valid or trap loads pc and -> FETCH; halt input ignored while in HALT.
REQ-028 stall with trap/redirect in FETCH: pc still loads target; stall only suppresses the request.
REQ-029 fetch_valid and misaligned never asserted while rst_n=0 or in BOOT/HALT.

Reset
REQ-030 rst_n=0 forces immediately, without clock: state=BOOT, pc=RESET_VECTOR, imem_req=0, fetch_valid=0, misaligned=0, pending cleared.
REQ-031 Reset during WAIT abandons the outstanding request; no fetch_valid for it.
REQ-032 First request issued on the second rising edge after rst_n deasserts (BOOT, then FETCH).

Verification
REQ-033 Reset release, imem_ready tied 1, no stall -> imem_req=1 from second cycle, pc 0,4,8,12, fetch_valid every cycle.
REQ-034 imem_ready low 3 cycles in WAIT, redirect_valid target 32'h100 in 2nd wait cycle -> addr held, completing fetch squashed, pc=32'h100 after ready.
REQ-035 Same-cycle trap and redirect target 32'h40 in FETCH -> pc=TRAP_VECTOR, fetch_valid=0 that cycle.
REQ-036 Redirect target 32'h0000_0102 -> misaligned pulse, pc=TRAP_VECTOR.
REQ-037 pc at 32'hFFFF_FFFC, fetch completes -> pc=0; then halt -> imem_req=0, pc frozen; redirect 32'h20 -> FETCH at 32'h20.
REQ-038 rst_n asserted mid-WAIT, asynchronous to clk -> pc=RESET_VECTOR and imem_req=0 before next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch request generation, redirect/trap
// steering and halt control for an in-order fetch stage.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  input  logic        halt,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_nx;
  logic        pend_valid;
  logic        pend_valid_nx;
  logic        pend_trap;
  logic        pend_trap_nx;
  logic [31:0] pend_target;
  logic [31:0] pend_target_nx;
  logic        cand_valid;
  logic        cand_trap;
  logic [31:0] cand_target;
  logic        bad_target;
  logic        done;

  assign bad_target = redirect_valid
                    && (redirect_target[1:0] != 2'b00);
  assign imem_addr  = pc;

  // Merge this cycle's trap/redirect into whatever is already pending;
  // a pending trap is never displaced by a plain redirect.
  always_comb begin
    cand_valid  = pend_valid;
    cand_trap   = pend_trap;
    cand_target = pend_target;
    if (trap || bad_target) begin
      cand_valid  = 1'b1;
      cand_trap   = 1'b1;
      cand_target = TRAP_VECTOR;
    end else if (redirect_valid
                 && !(pend_valid && pend_trap)) begin
      cand_valid  = 1'b1;
      cand_trap   = 1'b0;
      cand_target = redirect_target;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    pend_valid_nx  = pend_valid;
    pend_trap_nx   = pend_trap;
    pend_target_nx = pend_target;
    imem_req       = 1'b0;
    fetch_valid    = 1'b0;
    misaligned     = 1'b0;
    done           = 1'b0;
    unique case (state)
      BOOT: state_nx = FETCH;
      FETCH: begin
        imem_req   = !stall;
        misaligned = bad_target;
        done       = imem_req && imem_ready;
        if (cand_valid) begin
          pc_nx = cand_target;
        end else if (done) begin
          pc_nx       = pc + 32'd4;
          fetch_valid = 1'b1;
        end
        if (halt) begin
          state_nx = HALT;
        end else if (imem_req && !imem_ready
                     && !cand_valid) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        imem_req   = 1'b1;
        misaligned = bad_target;
        if (imem_ready) begin
          if (cand_valid) begin
            pc_nx = cand_target;
          end else begin
            pc_nx       = pc + 32'd4;
            fetch_valid = 1'b1;
          end
          pend_valid_nx = 1'b0;
          pend_trap_nx  = 1'b0;
          state_nx      = halt ? HALT : FETCH;
        end else begin
          pend_valid_nx  = cand_valid;
          pend_trap_nx   = cand_trap;
          pend_target_nx = cand_target;
        end
      end
      HALT: begin
        if (trap || redirect_valid) begin
          pc_nx    = cand_target;
          state_nx = FETCH;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_trap   <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      pend_valid  <= pend_valid_nx;
      pend_trap   <= pend_trap_nx;
      pend_target <= pend_target_nx;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        halt;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        misaligned;

  int n_cmp;
  int n_bad;

  pc_sequencer #(
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap           (trap),
    .halt           (halt),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the sequencer is doing, in plain terms.
  bit          m_booting, m_halted, m_waiting;
  bit          m_has_pend, m_pend_is_trap;
  logic [31:0] m_pc, m_pend_to;
  bit          n_booting, n_halted, n_waiting;
  bit          n_has_pend, n_pend_is_trap;
  logic [31:0] n_pc, n_pend_to;
  bit          e_req, e_fv, e_mis;

  task automatic model_reset();
    m_booting = 1; m_halted = 0; m_waiting = 0;
    m_has_pend = 0; m_pend_is_trap = 0;
    m_pc = RV; m_pend_to = 0;
    n_booting = 1; n_halted = 0; n_waiting = 0;
    n_has_pend = 0; n_pend_is_trap = 0;
    n_pc = RV; n_pend_to = 0;
    e_req = 0; e_fv = 0; e_mis = 0;
  endtask

  task automatic model_eval();
    bit          odd;
    bit          squash;
    bit          to_trap;
    logic [31:0] dest;
    bit          completes;
    n_booting = 0;
    n_halted = m_halted; n_waiting = m_waiting;
    n_has_pend = m_has_pend;
    n_pend_is_trap = m_pend_is_trap;
    n_pc = m_pc; n_pend_to = m_pend_to;
    e_req = 0; e_fv = 0; e_mis = 0;
    odd = redirect_valid
       && (redirect_target % 4 != 0);
    if (m_booting) return;
    if (m_halted) begin
      if (trap || redirect_valid) begin
        n_halted = 0;
        n_pc = (trap || odd) ? TV : redirect_target;
      end
      return;
    end
    e_mis = odd;
    e_req = m_waiting || !stall;
    squash = m_has_pend;
    to_trap = m_pend_is_trap;
    dest = m_pend_to;
    if (trap || odd) begin
      squash = 1; to_trap = 1; dest = TV;
    end else if (redirect_valid && !to_trap) begin
      squash = 1; dest = redirect_target;
    end
    completes = e_req && imem_ready;
    if (m_waiting && !completes) begin
      n_has_pend = squash;
      n_pend_is_trap = to_trap;
      n_pend_to = dest;
      return;
    end
    if (squash) n_pc = dest;
    else if (completes) begin
      n_pc = m_pc + 4;
      e_fv = 1;
    end
    n_has_pend = 0; n_pend_is_trap = 0;
    n_halted = halt;
    n_waiting = !m_waiting && !halt && !squash
             && e_req && !imem_ready;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_booting = n_booting; m_halted = n_halted;
      m_waiting = n_waiting; m_has_pend = n_has_pend;
      m_pend_is_trap = n_pend_is_trap;
      m_pc = n_pc; m_pend_to = n_pend_to;
    end
  end

  task automatic apply(
    input bit          s,
    input bit          rv,
    input logic [31:0] rt,
    input bit          tr,
    input bit          h,
    input bit          rdy
  );
    @(negedge clk);
    stall = s; redirect_valid = rv;
    redirect_target = rt; trap = tr;
    halt = h; imem_ready = rdy;
    model_eval();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    stall = 0; redirect_valid = 0;
    redirect_target = 0; trap = 0;
    halt = 0; imem_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_eval();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (pc !== RV || imem_req !== 1'b0
        || fetch_valid !== 1'b0 || misaligned !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold pc=%h req=%b fv=%b mis=%b",
               pc, imem_req, fetch_valid, misaligned);
    end
    do_reset();
    n_cmp++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL boot_cycle req=%b fv=%b want 0 0",
               imem_req, fetch_valid);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (imem_req !== 1'b1 || fetch_valid !== 1'b1
          || pc !== 32'(4 * i) || imem_addr !== pc) begin
        n_bad++;
        $display("FAIL seq_%0d pc=%h req=%b fv=%b want pc=%h",
                 i, pc, imem_req, fetch_valid, 32'(4 * i));
      end
    end
  endtask

  task automatic test_wait_redirect();
    logic [31:0] a;
    apply(0, 0, 0, 0, 0, 0);
    a = imem_addr;
    for (int i = 0; i < 3; i++) begin
      apply(0, i == 1, 32'h100, 0, 0, 0);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== a
          || fetch_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_hold_%0d addr=%h req=%b want %h",
                 i, imem_addr, imem_req, a);
      end
    end
    apply(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (fetch_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_squash fv=%b want 0", fetch_valid);
    end
    apply(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (pc !== 32'h100 || fetch_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_target pc=%h fv=%b want 00000100 1",
               pc, fetch_valid);
    end
  endtask

  task automatic test_trap_redirect();
    apply(0, 1, 32'h40, 1, 0, 1);
    n_cmp++;
    if (fetch_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_squash fv=%b want 0", fetch_valid);
    end
    apply(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (pc !== TV) begin
      n_bad++;
      $display("FAIL trap_prio pc=%h want %h", pc, TV);
    end
  endtask

  task automatic test_misaligned();
    apply(0, 1, 32'h0000_0102, 0, 0, 1);
    n_cmp++;
    if (misaligned !== 1'b1 || fetch_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_pulse mis=%b fv=%b want 1 0",
               misaligned, fetch_valid);
    end
    apply(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (misaligned !== 1'b0 || pc !== TV) begin
      n_bad++;
      $display("FAIL mis_after mis=%b pc=%h want 0 %h",
               misaligned, pc, TV);
    end
    apply(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_wrap_halt();
    apply(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (pc !== 32'hFFFF_FFFC || fetch_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_top pc=%h fv=%b", pc, fetch_valid);
    end
    apply(1, 0, 0, 0, 1, 0);
    n_cmp++;
    if (pc !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_zero pc=%h want 0", pc);
    end
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 0, i == 1, 1);
      n_cmp++;
      if (imem_req !== 1'b0 || pc !== 32'h0
          || fetch_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL halt_%0d req=%b pc=%h fv=%b",
                 i, imem_req, pc, fetch_valid);
      end
    end
    apply(0, 1, 32'h20, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (imem_req !== 1'b1 || pc !== 32'h20
        || fetch_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_resume req=%b pc=%h fv=%b",
               imem_req, pc, fetch_valid);
    end
  endtask

  task automatic test_async_reset();
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (pc !== RV || imem_req !== 1'b0
        || fetch_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst pc=%h req=%b fv=%b",
               pc, imem_req, fetch_valid);
    end
    do_reset();
    apply(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (pc !== RV || fetch_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL async_restart pc=%h fv=%b", pc, fetch_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 600; i++) begin
      t = $urandom;
      t[1:0] = ($urandom_range(3) == 0) ? t[1:0] : 2'b00;
      apply($urandom_range(3) == 0,
            $urandom_range(7) == 0, t,
            $urandom_range(11) == 0,
            $urandom_range(15) == 0,
            $urandom_range(2) != 0);
      n_cmp++;
      if (pc !== m_pc || imem_addr !== m_pc
          || imem_req !== e_req || fetch_valid !== e_fv
          || misaligned !== e_mis) begin
        n_bad++;
        $display("FAIL rand_%0d pc=%h/%h req=%b/%b fv=%b/%b mis=%b/%b",
                 i, pc, m_pc, imem_req, e_req,
                 fetch_valid, e_fv, misaligned, e_mis);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 0;
    stall = 0; redirect_valid = 0;
    redirect_target = 0; trap = 0;
    halt = 0; imem_ready = 1;
    model_reset();
    test_reset();
    test_sequential();
    test_wait_redirect();
    test_trap_redirect();
    test_misaligned();
    test_wrap_halt();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
